// File: rtl/div4b_ctrl_pkg.sv
// Shared constants for the sequential 4-bit restoring divider.
package div4b_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ITER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int         N_ITER   = 4;
    localparam logic [1:0] CNT_INIT = 2'(N_ITER - 1);

endpackage

// File: rtl/div4b_ctrl_if.sv
// Request/result bundle between a divider client (master) and div4b_ctrl (slave).
interface div4b_ctrl_if;
    logic       start;
    logic [3:0] A;
    logic [3:0] B;
    logic       busy;
    logic       done;
    logic [3:0] Q;
    logic [3:0] R;
    logic       div0;

    modport master (output start, A, B, input busy, done, Q, R, div0);
    modport slave  (input start, A, B, output busy, done, Q, R, div0);
endinterface

// File: rtl/div4b_ctrl_rest4b.sv
// 4-bit add/subtract unit: sel=1 computes A-B with Cout=1 meaning no borrow.
module rest4b (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       sel,
    output logic [3:0] Rest,
    output logic       Cout
);
    logic [4:0] sum;

    assign sum  = {1'b0, A} + {1'b0, B ^ {4{sel}}} + {4'd0, sel};
    assign Rest = sum[3:0];
    assign Cout = sum[4];
endmodule

// File: rtl/div4b_ctrl.sv
// Restoring divider: one trial subtraction per clock through rest4b, 4 iterations,
// then a one-cycle done pulse with Q/R/div0 held until the next accepted start.
module div4b_ctrl
    import div4b_ctrl_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    div4b_ctrl_if.slave  bus
);
    state_t     state, state_nxt;
    logic [3:0] rr, qr, br;
    logic [1:0] cnt;
    logic       div0_r;

    logic [4:0] trial;
    logic [3:0] rest;
    logic       cout, qbit;

    assign trial = {rr, qr[3]};

    rest4b u_rest (
        .A    (trial[3:0]),
        .B    (br),
        .sel  (1'b1),
        .Rest (rest),
        .Cout (cout)
    );

    // When trial[4] is set, trial > br, so the mod-16 difference is exact.
    assign qbit = trial[4] | cout;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (bus.start) state_nxt = S_ITER;
            S_ITER:  if (cnt == 2'd0) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            rr     <= 4'd0;
            qr     <= 4'd0;
            br     <= 4'd0;
            cnt    <= 2'd0;
            div0_r <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (bus.start) begin
                    rr     <= 4'd0;
                    qr     <= bus.A;
                    br     <= bus.B;
                    div0_r <= (bus.B == 4'd0);
                    cnt    <= CNT_INIT;
                end
                S_ITER: begin
                    rr  <= qbit ? rest : trial[3:0];
                    qr  <= {qr[2:0], qbit};
                    cnt <= cnt - 2'd1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state != S_IDLE);
    assign bus.done = (state == S_DONE);
    assign bus.Q    = qr;
    assign bus.R    = rr;
    assign bus.div0 = div0_r;

endmodule
